// File: rtl/sid_master_pkg.sv
// Shared types for the SID bus master: FSM states, queued command layout and
// bus widths.
package sid_master_pkg;

  localparam int SID_ADDR_W  = 5;
  localparam int SID_DATA_W  = 8;
  localparam int SID_DELAY_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // The delay field is sized for the widest supported DELAY_W.
  typedef struct packed {
    logic                   read;
    logic [SID_ADDR_W-1:0]  addr;
    logic [SID_DATA_W-1:0]  data;
    logic [SID_DELAY_W-1:0] delay;
  } cmd_t;

endpackage

// File: rtl/sid_cmd_fifo.sv
// Single-clock synchronous FIFO with full/empty flags; pointers carry one
// extra wrap bit so that full and empty can be told apart.
module sid_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sid_bus_master.sv
// Timed register-access initiator for the SID port. Define
// SID_MASTER_READBACK_EN to make read commands capture and return iDataR.
module sid_bus_master
  import sid_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DELAY_W    = 16
) (
  input  logic                  clk,
  input  logic                  iRst,
  input  logic                  clkEn,
  input  logic                  iCmdValid,
  output logic                  oCmdReady,
  input  logic                  iCmdRead,
  input  logic [SID_ADDR_W-1:0] iCmdAddr,
  input  logic [7:0]            iCmdData,
  input  logic [DELAY_W-1:0]    iCmdDelay,
  output logic                  oWE,
  output logic [SID_ADDR_W-1:0] oAddr,
  output logic [7:0]            oDataW,
  input  logic [7:0]            iDataR,
  output logic                  oRspValid,
  output logic [7:0]            oRspData,
  output logic                  oBusy
);

  cmd_t               push_cmd;
  cmd_t               head_cmd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               access;
  state_t             state;
  state_t             state_nxt;
  logic [DELAY_W-1:0] cnt;
  logic               rd_pending;

  assign push_cmd = '{read: iCmdRead, addr: iCmdAddr, data: iCmdData,
                      delay: SID_DELAY_W'(iCmdDelay)};

  sid_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (iRst),
    .push  (iCmdValid),
    .wdata (push_cmd),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (head_cmd),
    .empty (fifo_empty)
  );

  assign oCmdReady = !fifo_full;
  assign oBusy     = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (clkEn && (cnt == '0)) begin
          access    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are latched at pop so they are settled before the access tick.
  always_ff @(posedge clk) begin
    if (iRst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_pending <= 1'b0;
      oAddr      <= '0;
      oDataW     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        oAddr      <= head_cmd.addr;
        oDataW     <= head_cmd.data;
        rd_pending <= head_cmd.read;
        cnt        <= head_cmd.delay[DELAY_W-1:0];
      end else if ((state == WAIT) && clkEn && (cnt != '0)) begin
        cnt <= cnt - DELAY_W'(1);
      end
    end
  end

  // Gated by reset so no strobe can escape during the reset cycle.
  assign oWE = access && !rd_pending && !iRst;

`ifdef SID_MASTER_READBACK_EN
  logic rsp_valid;

  always_ff @(posedge clk) begin
    if (iRst) begin
      rsp_valid <= 1'b0;
      oRspData  <= '0;
    end else begin
      rsp_valid <= access && rd_pending;
      if (access && rd_pending) oRspData <= iDataR;
    end
  end

  assign oRspValid = rsp_valid && !iRst;
`else
  logic unused_data_r;

  assign unused_data_r = ^iDataR;
  assign oRspValid     = 1'b0;
  assign oRspData      = '0;
`endif

endmodule

// File: tb/tb_sid_bus_master.sv
// Scoreboard bench for sid_bus_master: random and directed commands are checked
// against a tick-counting model of when each access must land.
module tb_sid_bus_master;

  localparam int FIFO_DEPTH = 4;
  localparam int DELAY_W    = 16;
`ifdef SID_MASTER_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic               clk;
  logic               iRst;
  logic               clkEn;
  logic               iCmdValid;
  logic               oCmdReady;
  logic               iCmdRead;
  logic [4:0]         iCmdAddr;
  logic [7:0]         iCmdData;
  logic [DELAY_W-1:0] iCmdDelay;
  logic               oWE;
  logic [4:0]         oAddr;
  logic [7:0]         oDataW;
  logic [7:0]         iDataR;
  logic               oRspValid;
  logic [7:0]         oRspData;
  logic               oBusy;

  sid_bus_master #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DELAY_W    (DELAY_W)
  ) dut (
    .clk       (clk),
    .iRst      (iRst),
    .clkEn     (clkEn),
    .iCmdValid (iCmdValid),
    .oCmdReady (oCmdReady),
    .iCmdRead  (iCmdRead),
    .iCmdAddr  (iCmdAddr),
    .iCmdData  (iCmdData),
    .iCmdDelay (iCmdDelay),
    .oWE       (oWE),
    .oAddr     (oAddr),
    .oDataW    (oDataW),
    .iDataR    (iDataR),
    .oRspValid (oRspValid),
    .oRspData  (oRspData),
    .oBusy     (oBusy)
  );

  typedef struct {
    bit          rd;
    bit [4:0]    addr;
    bit [7:0]    data;
    int unsigned remaining;
    longint      push;
  } ent_t;

  ent_t   sb[$];
  longint cyc;
  longint last_acc;
  bit     rsp_pending;
  longint rsp_due;
  bit [7:0] rsp_val;
  int     checks;
  int     errors;
  bit     mon_en;
  bit     en_run;
  int     en_period;
  int     phase;
  bit     force_dr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // clkEn pulses once every en_period clocks; iDataR changes every cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!en_run) begin
        clkEn = 1'b0;
        phase = 0;
      end else begin
        clkEn = (phase == 0);
        phase++;
        if (phase >= en_period) phase = 0;
      end
      iDataR = force_dr ? 8'hA5 : 8'($urandom);
    end
  end

  // Reference model: an access lands on the (delay+1)-th clkEn tick counted
  // from two cycles after both its acceptance and the previous access.
  always @(negedge clk) begin
    longint c;
    longint start;
    int     n_fifo;
    bit     acc;
    bit     exp_we;
    bit     exp_rv;
    ent_t   e;
    if (mon_en) begin
      c = cyc;
      if (iRst) begin
        checkOutput("we_in_reset", oWE, 0);
        checkOutput("rsp_in_reset", oRspValid, 0);
        sb.delete();
        last_acc    = -100;
        rsp_pending = 1'b0;
      end else begin
        n_fifo = 0;
        acc    = 1'b0;
        exp_we = 1'b0;
        foreach (sb[i]) if (i > 0 && sb[i].push + 1 <= c) n_fifo++;
        if (sb.size() > 0) begin
          start = ((sb[0].push > last_acc) ? sb[0].push : last_acc) + 2;
          if (sb[0].push + 1 <= c && c <= start - 1) n_fifo++;
          if (c >= start && clkEn) begin
            if (sb[0].remaining == 0) acc = 1'b1;
            else sb[0].remaining = sb[0].remaining - 1;
          end
          exp_we = acc && !sb[0].rd;
        end
        checkOutput("ready", oCmdReady, n_fifo < FIFO_DEPTH);
        checkOutput("busy", oBusy, (sb.size() > 0) && (sb[0].push + 1 <= c));
        if (oWE || exp_we) checkOutput("we_strobe", oWE, exp_we);
        exp_rv = rsp_pending && (rsp_due == c);
        if (oRspValid || exp_rv) checkOutput("rsp_valid", oRspValid, exp_rv);
        if (exp_rv) begin
          checkOutput("rsp_data", oRspData, rsp_val);
          rsp_pending = 1'b0;
        end
        if (acc) begin
          checkOutput("access_addr", oAddr, sb[0].addr);
          if (!sb[0].rd) begin
            checkOutput("access_data", oDataW, sb[0].data);
          end else if (READBACK) begin
            rsp_pending = 1'b1;
            rsp_due     = c + 1;
            rsp_val     = iDataR;
          end
          void'(sb.pop_front());
          last_acc = c;
        end
        if (iCmdValid && oCmdReady) begin
          e.rd        = iCmdRead;
          e.addr      = iCmdAddr;
          e.data      = iCmdData;
          e.remaining = iCmdDelay;
          e.push      = c;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one command and returns once it has been accepted (or timed out).
  task automatic applyStimulus(input bit rd, input bit [4:0] addr, input bit [7:0] data,
                               input bit [DELAY_W-1:0] delay);
    int k;
    iCmdValid = 1'b1;
    iCmdRead  = rd;
    iCmdAddr  = addr;
    iCmdData  = data;
    iCmdDelay = delay;
    k = 0;
    forever begin
      @(negedge clk);
      if (oCmdReady) break;
      k++;
      if (k >= 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL push_timeout: command addr 0x%0h not accepted, required within 500 cycles", addr);
        break;
      end
    end
    @(posedge clk);
    #1;
    iCmdValid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while ((sb.size() > 0 || rsp_pending) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d commands outstanding, required 0 after %0d cycles", sb.size(), budget);
    end
    idle(3);
  endtask

  initial begin
    iRst      = 1'b1;
    iCmdValid = 1'b0;
    iCmdRead  = 1'b0;
    iCmdAddr  = '0;
    iCmdData  = '0;
    iCmdDelay = '0;
    iDataR    = '0;
    clkEn     = 1'b0;
    en_run    = 1'b1;
    en_period = 4;
    force_dr  = 1'b0;
    last_acc  = -100;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    iRst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", oCmdReady, 1);
    checkOutput("reset_we", oWE, 0);
    checkOutput("reset_addr", oAddr, 0);
    checkOutput("reset_dataw", oDataW, 0);
    checkOutput("reset_rsp_valid", oRspValid, 0);
    checkOutput("reset_rsp_data", oRspData, 0);
    checkOutput("reset_busy", oBusy, 0);
    @(posedge clk);
    #1;

    $display("[TB] single and delayed writes");
    applyStimulus(1'b0, 5'h18, 8'h1F, 16'd0);
    waitDrain(200);
    applyStimulus(1'b0, 5'h04, 8'h41, 16'd3);
    waitDrain(200);

    $display("[TB] read access");
    force_dr = 1'b1;
    applyStimulus(1'b1, 5'h1B, 8'h00, 16'd1);
    waitDrain(200);
    checkOutput("read_rsp_hold", oRspData, READBACK ? 8'hA5 : 8'h00);
    force_dr = 1'b0;

    $display("[TB] queue full with clkEn held low");
    en_run = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'(i), 8'(8'h10 + i), 16'd0);
    idle(4);
    @(negedge clk);
    checkOutput("full_ready", oCmdReady, 0);
    @(posedge clk);
    #1;
    en_run    = 1'b1;
    en_period = 3;
    waitDrain(200);

    $display("[TB] reset during wait");
    en_period = 4;
    applyStimulus(1'b0, 5'h01, 8'h11, 16'd10);
    applyStimulus(1'b0, 5'h02, 8'h22, 16'd0);
    applyStimulus(1'b0, 5'h03, 8'h33, 16'd0);
    idle(4);
    iRst = 1'b1;
    @(posedge clk);
    #1;
    iRst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", oBusy, 0);
    checkOutput("post_reset_ready", oCmdReady, 1);
    @(posedge clk);
    #1;
    idle(60);

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) en_period = $urandom_range(1, 5);
      applyStimulus($urandom_range(0, 2) == 0, 5'($urandom), 8'($urandom),
                    DELAY_W'($urandom_range(0, 5)));
      idle($urandom_range(0, 3));
    end
    waitDrain(5000);

    $display("[TB] maximum delay");
    en_period = 1;
    applyStimulus(1'b0, 5'h1F, 8'h5A, 16'hFFFF);
    waitDrain(70000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
